// File: rtl/fmap_load_scheduler_pkg.sv
// Shared definitions for the feature-map load scheduler: default widths,
// state encoding and the layer-configuration validity check.
package fmap_load_scheduler_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned COL_W      = 8;
    localparam int unsigned MAX_PIXELS = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_FULL_REQ     = 3'd1;
    localparam logic [2:0] ST_FULL_WAIT    = 3'd2;
    localparam logic [2:0] ST_COMPUTE      = 3'd3;
    localparam logic [2:0] ST_COMPUTE_WAIT = 3'd4;
    localparam logic [2:0] ST_SLIDE_REQ    = 3'd5;
    localparam logic [2:0] ST_SLIDE_WAIT   = 3'd6;
    localparam logic [2:0] ST_DONE         = 3'd7;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        FULL_REQ     = ST_FULL_REQ,
        FULL_WAIT    = ST_FULL_WAIT,
        COMPUTE      = ST_COMPUTE,
        COMPUTE_WAIT = ST_COMPUTE_WAIT,
        SLIDE_REQ    = ST_SLIDE_REQ,
        SLIDE_WAIT   = ST_SLIDE_WAIT,
        DONE         = ST_DONE
    } state_e;

    // A band is runnable when the window is non-empty, fits in the band,
    // and the full-window pixel count fits in the scratch pad.
    function automatic logic cfg_ok(input int unsigned kc,
                                    input int unsigned cl,
                                    input int unsigned tc,
                                    input int unsigned prod,
                                    input int unsigned max_pix);
        return (kc != 0) && (cl != 0) && (kc <= tc) && (prod <= max_pix);
    endfunction

endpackage

// File: rtl/fmap_load_scheduler.sv
// Load/compute sequencer for one row band: one full-window load, then a
// compute per window position with single-column slides in between.
// Handshakes are pulse based: each *_start output is a one-cycle request
// and the matching fmap_ready_to_pe / pe_compute_done pulse completes it;
// completion pulses are only honoured in the state that waits for them.
module fmap_load_scheduler
    import fmap_load_scheduler_pkg::*;
#(
    parameter int ADDRESSWIDTH_F_PAD = ADDR_W,
    parameter int COL_WIDTH          = COL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          layer_start,
    input  logic                          abort,
    input  logic [COL_WIDTH-1:0]          kernel_cols,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] col_len,
    input  logic [COL_WIDTH-1:0]          total_cols,
    output logic                          fmap_load_start,
    output logic                          load_full_cloumn,
    output logic [ADDRESSWIDTH_F_PAD-1:0] load_one_cloumn_num,
    output logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
    input  logic                          fmap_ready_to_pe,
    output logic                          pe_compute_start,
    input  logic                          pe_compute_done,
    output logic [COL_WIDTH-1:0]          col_index,
    output logic                          busy,
    output logic                          layer_done,
    output logic                          cfg_err
);

    localparam int          PW      = COL_WIDTH + ADDRESSWIDTH_F_PAD;
    localparam int unsigned MAX_PIX = 1 << ADDRESSWIDTH_F_PAD;

    state_e                          state_q, state_d;
    logic [COL_WIDTH-1:0]            kc_q, tc_q, col_index_q;
    logic [ADDRESSWIDTH_F_PAD-1:0]   pixel_num_q, load_one_q;
    logic                            load_start_q, load_full_q, pe_start_q, cfg_err_q;
    logic [PW-1:0]                   prod;
    logic                            start_ok, accept;

    assign prod     = PW'(kernel_cols) * PW'(col_len);
    assign start_ok = cfg_ok(32'(kernel_cols), 32'(col_len), 32'(total_cols),
                             32'(prod), MAX_PIX);
    assign accept   = !abort && (state_q == IDLE) && layer_start && start_ok;

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:         if (layer_start && start_ok) state_d = FULL_REQ;
                FULL_REQ:     state_d = FULL_WAIT;
                FULL_WAIT:    if (fmap_ready_to_pe) state_d = COMPUTE;
                COMPUTE:      state_d = COMPUTE_WAIT;
                COMPUTE_WAIT: if (pe_compute_done)
                                  state_d = (col_index_q == tc_q) ? DONE : SLIDE_REQ;
                SLIDE_REQ:    state_d = SLIDE_WAIT;
                SLIDE_WAIT:   if (fmap_ready_to_pe) state_d = COMPUTE;
                DONE:         state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered request pulses, latched config and column counter. The
    // request pulses trail their REQ/COMPUTE state by one cycle, which gives
    // the two-cycle trigger-to-request latency; abort suppresses them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_q         <= '0;
            tc_q         <= '0;
            col_index_q  <= '0;
            pixel_num_q  <= '0;
            load_one_q   <= '0;
            load_start_q <= 1'b0;
            load_full_q  <= 1'b0;
            pe_start_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            load_start_q <= !abort && ((state_q == FULL_REQ) || (state_q == SLIDE_REQ));
            pe_start_q   <= !abort && (state_q == COMPUTE);
            cfg_err_q    <= !abort && (state_q == IDLE) && layer_start && !start_ok;
            if (!abort && state_q == FULL_REQ)  load_full_q <= 1'b1;
            if (!abort && state_q == SLIDE_REQ) load_full_q <= 1'b0;
            // Config is only taken on an accepted start so a rejected one
            // leaves the previous band's outputs untouched.
            if (accept) begin
                kc_q        <= kernel_cols;
                tc_q        <= total_cols;
                load_one_q  <= col_len;
                pixel_num_q <= prod[ADDRESSWIDTH_F_PAD-1:0];
                col_index_q <= '0;
            end
            if (!abort && state_q == FULL_WAIT && fmap_ready_to_pe)
                col_index_q <= kc_q;
            if (!abort && state_q == SLIDE_WAIT && fmap_ready_to_pe)
                col_index_q <= col_index_q + COL_WIDTH'(1);
        end
    end

    assign fmap_load_start     = load_start_q;
    assign load_full_cloumn    = load_full_q;
    assign load_one_cloumn_num = load_one_q;
    assign pixel_num           = pixel_num_q;
    assign pe_compute_start    = pe_start_q;
    assign col_index           = col_index_q;
    assign busy                = (state_q != IDLE);
    assign layer_done          = (state_q == DONE);
    assign cfg_err             = cfg_err_q;

endmodule
